// File: rtl/uart_hex_printer_pkg.sv
// Shared constants and state encoding for the hex printer.
// Imported by the printer top and its nibble converter.
package uart_hex_printer_pkg;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_A  = 8'h41;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit to uppercase hex ASCII converter.
// Reusable by any dump/formatter block.
module nibble_to_ascii
    import uart_hex_printer_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // Digits map onto '0'..'9', letters onto 'A'..'F'
    always_comb begin
        if (nibble < 4'd10) begin
            ascii = CHAR_0 + {4'h0, nibble};
        end else begin
            ascii = CHAR_A + ({4'h0, nibble} - 8'd10);
        end
    end

endmodule

// File: rtl/uart_hex_printer.sv
// Prints a 32-bit word as hex ASCII (MSB nibble first, optional CR LF)
// over the uart_tx ready/data_strobe handshake.
module uart_hex_printer
    import uart_hex_printer_pkg::*;
#(
    parameter int DIGITS  = 8,
    parameter int NEWLINE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        value_strobe,
    output logic        ready,
    output logic        overrun,
    output logic [7:0]  uart_data,
    output logic        uart_strobe,
    input  logic        uart_ready
);

    localparam logic [3:0] LAST_IDX   = 4'(DIGITS + 2 * NEWLINE - 1);
    localparam logic [3:0] LAST_DIGIT = 4'(DIGITS - 1);
    localparam logic [3:0] CR_IDX     = 4'(DIGITS);

    state_t      state;
    state_t      state_next;
    logic [3:0]  index;
    logic [31:0] shadow;
    logic        accept;
    logic        issue;
    logic        last_char;
    logic [3:0]  pos;
    logic [3:0]  nibble;
    logic [7:0]  digit_char;
    logic [7:0]  next_char;

    nibble_to_ascii u_nibble (
        .nibble (nibble),
        .ascii  (digit_char)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave IDLE on a request, return after the last character
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (value_strobe) state_next = EMIT;
            EMIT: if (issue && last_char) state_next = IDLE;
        endcase
    end

    // Issue decode and character selection; the strobe guard blocks
    // back-to-back issues while the sink's ready still lags by a cycle
    always_comb begin
        accept    = (state == IDLE) && value_strobe;
        issue     = (state == EMIT) && uart_ready && !uart_strobe;
        last_char = (index == LAST_IDX);
        pos       = LAST_DIGIT - index;
        nibble    = 4'(shadow >> {pos, 2'b00});
        if (index <= LAST_DIGIT) begin
            next_char = digit_char;
        end else if (index == CR_IDX) begin
            next_char = CHAR_CR;
        end else begin
            next_char = CHAR_LF;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow      <= '0;
            index       <= '0;
            uart_data   <= '0;
            uart_strobe <= 1'b0;
            ready       <= 1'b1;
            overrun     <= 1'b0;
        end else begin
            uart_strobe <= issue;
            ready       <= (state_next == IDLE);
            if (accept) begin
                shadow <= value;
                index  <= '0;
            end
            if (issue) begin
                uart_data <= next_char;
                index     <= index + 4'd1;
            end
            if (value_strobe && !ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_hex_printer.sv
// Directed self-checking bench for uart_hex_printer.
// Covers default and DIGITS=2/NEWLINE=0 instances.
module tb_uart_hex_printer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        value_strobe;
    logic        ready;
    logic        overrun;
    logic [7:0]  uart_data;
    logic        uart_strobe;
    logic        uart_ready;

    logic [31:0] value2;
    logic        value_strobe2;
    logic        ready2;
    logic        overrun2;
    logic [7:0]  uart_data2;
    logic        uart_strobe2;
    logic        uart_ready2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc   = 0;
    int viol  = 0;
    int hold  = 0;
    bit sink_mode = 1'b0;

    logic [7:0] q[$];
    int         tq[$];
    logic [7:0] q2[$];

    uart_hex_printer dut (
        .clk          (clk),
        .reset        (reset),
        .value        (value),
        .value_strobe (value_strobe),
        .ready        (ready),
        .overrun      (overrun),
        .uart_data    (uart_data),
        .uart_strobe  (uart_strobe),
        .uart_ready   (uart_ready)
    );

    uart_hex_printer #(.DIGITS(2), .NEWLINE(0)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .value        (value2),
        .value_strobe (value_strobe2),
        .ready        (ready2),
        .overrun      (overrun2),
        .uart_data    (uart_data2),
        .uart_strobe  (uart_strobe2),
        .uart_ready   (uart_ready2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sink model: capture characters, optionally hold ready low 50 cycles
    always @(negedge clk) begin
        if (uart_strobe) begin
            q.push_back(uart_data);
            tq.push_back(cyc);
            if (!uart_ready) viol = viol + 1;
        end
        if (sink_mode && uart_strobe) begin
            hold = 50;
            uart_ready = 1'b0;
        end else if (hold > 0) begin
            hold = hold - 1;
            if (hold == 0) uart_ready = 1'b1;
        end
        if (uart_strobe2) q2.push_back(uart_data2);
    end

    task automatic send(input logic [31:0] v);
        @(negedge clk);
        value = v;
        value_strobe = 1'b1;
        @(negedge clk);
        acc = cyc;
        value_strobe = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", ready);
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_overrun got=%b want=0", overrun);
        end
        total++;
        if (uart_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_data got=%h want=00", uart_data);
        end
        total++;
        if (uart_strobe !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobe got=%b want=0", uart_strobe);
        end
        total++;
        if (ready2 !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready2 got=%b want=1", ready2);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] e [10];
        logic [7:0] g;
        bit ok;
        e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41,
              8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        q.delete();
        tq.delete();
        send(32'h1234ABCD);
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_timeout ready got=0 want=1");
        end
        repeat (5) @(negedge clk);
        total++;
        if (q.size() != 10) begin
            bad++;
            $display("FAIL basic_count got=%0d want=10", q.size());
        end
        for (int i = 0; i < 10; i++) begin
            g = (i < q.size()) ? q[i] : 8'hxx;
            total++;
            if (g !== e[i]) begin
                bad++;
                $display("FAIL basic_char%0d got=%h want=%h", i, g, e[i]);
            end
            total++;
            if (i < tq.size() && tq[i] != acc + 1 + 2 * i) begin
                bad++;
                $display("FAIL basic_time%0d got=%0d want=%0d",
                         i, tq[i], acc + 1 + 2 * i);
            end
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_ready got=%b want=1", ready);
        end
    endtask

    task automatic test_hex_boundaries;
        logic [7:0] e [10];
        logic [7:0] g;
        bit ok;
        e = '{8'h39, 8'h41, 8'h30, 8'h46, 8'h46,
              8'h30, 8'h41, 8'h39, 8'h0D, 8'h0A};
        q.delete();
        send(32'h9A0FF0A9);
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL hex_timeout ready got=0 want=1");
        end
        repeat (5) @(negedge clk);
        total++;
        if (q.size() != 10) begin
            bad++;
            $display("FAIL hex_count got=%0d want=10", q.size());
        end
        for (int i = 0; i < 10; i++) begin
            g = (i < q.size()) ? q[i] : 8'hxx;
            total++;
            if (g !== e[i]) begin
                bad++;
                $display("FAIL hex_char%0d got=%h want=%h", i, g, e[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] e [10];
        logic [7:0] g;
        bit ok;
        e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41,
              8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        q.delete();
        tq.delete();
        viol = 0;
        sink_mode = 1'b1;
        send(32'h1234ABCD);
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_timeout ready got=0 want=1");
        end
        sink_mode = 1'b0;
        repeat (60) @(negedge clk);
        total++;
        if (q.size() != 10) begin
            bad++;
            $display("FAIL bp_count got=%0d want=10", q.size());
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL bp_not_ready_issue got=%0d want=0", viol);
        end
        for (int i = 0; i < 10; i++) begin
            g = (i < q.size()) ? q[i] : 8'hxx;
            total++;
            if (g !== e[i]) begin
                bad++;
                $display("FAIL bp_char%0d got=%h want=%h", i, g, e[i]);
            end
        end
        for (int i = 1; i < tq.size(); i++) begin
            total++;
            if (tq[i] - tq[i-1] < 51) begin
                bad++;
                $display("FAIL bp_gap%0d got=%0d want>=51",
                         i, tq[i] - tq[i-1]);
            end
        end
    endtask

    task automatic test_param;
        bit ok;
        logic [7:0] g;
        q2.delete();
        @(negedge clk);
        value2 = 32'hFFFF_FF0F;
        value_strobe2 = 1'b1;
        @(negedge clk);
        value_strobe2 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (ready2) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL param_timeout ready2 got=0 want=1");
        end
        repeat (5) @(negedge clk);
        total++;
        if (q2.size() != 2) begin
            bad++;
            $display("FAIL param_count got=%0d want=2", q2.size());
        end
        g = (q2.size() > 0) ? q2[0] : 8'hxx;
        total++;
        if (g !== 8'h30) begin
            bad++;
            $display("FAIL param_char0 got=%h want=30", g);
        end
        g = (q2.size() > 1) ? q2[1] : 8'hxx;
        total++;
        if (g !== 8'h46) begin
            bad++;
            $display("FAIL param_char1 got=%h want=46", g);
        end
        total++;
        if (overrun2 !== 1'b0) begin
            bad++;
            $display("FAIL param_overrun got=%b want=0", overrun2);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] e [10];
        logic [7:0] g;
        bit ok;
        e = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42,
              8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        q.delete();
        send(32'hDEADBEEF);
        repeat (3) @(negedge clk);
        value = 32'h0;
        value_strobe = 1'b1;
        @(negedge clk);
        value_strobe = 1'b0;
        #1;
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_set got=%b want=1", overrun);
        end
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ovr_timeout ready got=0 want=1");
        end
        repeat (5) @(negedge clk);
        total++;
        if (q.size() != 10) begin
            bad++;
            $display("FAIL ovr_count got=%0d want=10", q.size());
        end
        for (int i = 0; i < 10; i++) begin
            g = (i < q.size()) ? q[i] : 8'hxx;
            total++;
            if (g !== e[i]) begin
                bad++;
                $display("FAIL ovr_char%0d got=%h want=%h", i, g, e[i]);
            end
        end
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_sticky got=%b want=1", overrun);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e [20];
        logic [7:0] g;
        bit ok;
        e = '{8'h43, 8'h41, 8'h46, 8'h45, 8'h30,
              8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A,
              8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
              8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL b2b_clear got=%b want=0", overrun);
        end
        q.delete();
        tq.delete();
        send(32'hCAFE0123);
        for (int i = 0; i < 100 && cyc != acc + 18; i++) @(negedge clk);
        value = 32'h0;
        value_strobe = 1'b1;
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready_rise got=%b want=1", ready);
        end
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL b2b_edge_overrun got=%b want=1", overrun);
        end
        value = 32'h0000_0001;
        @(negedge clk);
        value_strobe = 1'b0;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept got=%b want=0", ready);
        end
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_timeout ready got=0 want=1");
        end
        repeat (5) @(negedge clk);
        total++;
        if (q.size() != 20) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=20", q.size());
        end
        for (int i = 0; i < 20; i++) begin
            g = (i < q.size()) ? q[i] : 8'hxx;
            total++;
            if (g !== e[i]) begin
                bad++;
                $display("FAIL b2b_char%0d got=%h want=%h", i, g, e[i]);
            end
        end
        if (tq.size() > 10) begin
            total++;
            if (tq[9] != acc + 19 || tq[10] != acc + 21) begin
                bad++;
                $display("FAIL b2b_time got=%0d,%0d want=%0d,%0d",
                         tq[9], tq[10], acc + 19, acc + 21);
            end
        end
    endtask

    task automatic test_reset_mid_print;
        logic [7:0] e [10];
        logic [7:0] g;
        bit ok;
        e = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
              8'h30, 8'h30, 8'h39, 8'h0D, 8'h0A};
        q.delete();
        send(32'h1234ABCD);
        @(negedge clk);
        value = 32'h0;
        value_strobe = 1'b1;
        @(negedge clk);
        value_strobe = 1'b0;
        for (int i = 0; i < 200 && q.size() < 3; i++) begin
            @(negedge clk);
            #1;
        end
        total++;
        if (q.size() != 3) begin
            bad++;
            $display("FAIL rst_third got=%0d want=3", q.size());
        end
        reset = 1'b1;
        #1;
        total++;
        if (uart_strobe !== 1'b0) begin
            bad++;
            $display("FAIL rst_strobe got=%b want=0", uart_strobe);
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready got=%b want=1", ready);
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL rst_overrun got=%b want=0", overrun);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        total++;
        if (q.size() != 3) begin
            bad++;
            $display("FAIL rst_resume got=%0d want=3", q.size());
        end
        q.delete();
        send(32'h0000_0009);
        wait_idle(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rst_follow_timeout ready got=0 want=1");
        end
        repeat (5) @(negedge clk);
        total++;
        if (q.size() != 10) begin
            bad++;
            $display("FAIL rst_follow_count got=%0d want=10", q.size());
        end
        for (int i = 0; i < 10; i++) begin
            g = (i < q.size()) ? q[i] : 8'hxx;
            total++;
            if (g !== e[i]) begin
                bad++;
                $display("FAIL rst_follow_char%0d got=%h want=%h",
                         i, g, e[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        value = 32'h0;
        value_strobe = 1'b0;
        uart_ready = 1'b1;
        value2 = 32'h0;
        value_strobe2 = 1'b0;
        uart_ready2 = 1'b1;
        test_reset();
        test_basic();
        test_hex_boundaries();
        test_backpressure();
        test_param();
        test_overrun();
        test_back_to_back();
        test_reset_mid_print();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
